// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and
// drives the IF/ID register, inserting NOP bubbles on slow memory or redirect.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [15:0] redirect_pc_in,
    output logic        imem_req_out,
    output logic [15:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [15:0] imem_data_in,
    output logic [15:0] instruc_out,
    output logic [15:0] pc_out,
    output logic        valid_out
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [15:0] w_pc_inc;
    logic [15:0] r_hold_buf;
    logic [15:0] w_hold_buf_nxt;
    logic [15:0] r_hold_pc;
    logic [15:0] w_hold_pc_nxt;
    logic [15:0] r_instr;
    logic [15:0] w_instr_nxt;
    logic [15:0] r_pc_out;
    logic [15:0] w_pc_out_nxt;
    logic        r_valid;
    logic        w_valid_nxt;

    assign w_pc_inc = r_pc + 16'd1;

    always_comb begin
        // NOTE: every signal assigned here gets its hold value first, so no path can infer a latch.
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_hold_buf_nxt = r_hold_buf;
        w_hold_pc_nxt  = r_hold_pc;
        w_instr_nxt    = r_instr;
        w_pc_out_nxt   = r_pc_out;
        w_valid_nxt    = r_valid;

        if (redirect_in) begin
            // Redirect outranks stall and ack: any same-cycle ack and held word are discarded.
            w_state_nxt = S_FETCH;
            w_pc_nxt    = redirect_pc_in;
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack_in) begin
                        if (stall_in) begin
                            w_hold_buf_nxt = imem_data_in;
                            w_hold_pc_nxt  = r_pc;
                            w_state_nxt    = S_HOLD;
                        end else begin
                            w_instr_nxt  = imem_data_in;
                            w_pc_out_nxt = r_pc;
                            w_valid_nxt  = 1'b1;
                            w_pc_nxt     = w_pc_inc;
                        end
                    end else if (!stall_in) begin
                        w_instr_nxt = NOP_INSTR;
                        w_valid_nxt = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall_in) begin
                        w_instr_nxt  = r_hold_buf;
                        w_pc_out_nxt = r_hold_pc;
                        w_valid_nxt  = 1'b1;
                        w_pc_nxt     = w_pc_inc;
                        w_state_nxt  = S_FETCH;
                    end
                end
                default: w_state_nxt = S_FETCH;
            endcase
        end
    end

    // NOTE: the hold buffer carries no reset; it is only read in HOLD, which is always entered by writing it.
    always_ff @(posedge clk) begin
        r_hold_buf <= w_hold_buf_nxt;
        r_hold_pc  <= w_hold_pc_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_instr  <= NOP_INSTR;
            r_pc_out <= 16'h0000;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_pc_out <= w_pc_out_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    assign imem_req_out  = (r_state == S_FETCH) && !rst;
    assign imem_addr_out = r_pc;
    assign instruc_out   = r_instr;
    assign pc_out        = r_pc_out;
    assign valid_out     = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the driver pushes each accepted fetch into a
// scoreboard queue; a monitor pops one entry per instruction decode consumes.
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam logic [15:0] DATA_XOR  = 16'hA500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        redirect_in = 1'b0;
    logic [15:0] redirect_pc_in = 16'h0000;
    logic        imem_ack_in = 1'b0;
    logic [15:0] imem_data_in = 16'h0000;
    logic        imem_req_out;
    logic [15:0] imem_addr_out;
    logic [15:0] instruc_out;
    logic [15:0] pc_out;
    logic        valid_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard entries are {instruction, pc} in the order decode must see them.
    logic [31:0] sb_q[$];

    // Bench-side expectation of PC, HOLD occupancy and valid_out.
    logic [15:0] m_pc    = RESET_PC;
    logic        m_hold  = 1'b0;
    logic        m_valid = 1'b0;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_in      (stall_in),
        .redirect_in   (redirect_in),
        .redirect_pc_in(redirect_pc_in),
        .imem_req_out  (imem_req_out),
        .imem_addr_out (imem_addr_out),
        .imem_ack_in   (imem_ack_in),
        .imem_data_in  (imem_data_in),
        .instruc_out   (instruc_out),
        .pc_out        (pc_out),
        .valid_out     (valid_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: decode consumes the IF/ID word at each edge where it is valid,
    // not stalled and not flushed by a redirect or reset.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            if (!valid_out) begin
                check("bubble_is_nop", {16'h0000, instruc_out}, {16'h0000, NOP_INSTR});
            end else if (!stall_in && !redirect_in) begin
                check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("ifid_instr", {16'h0000, instruc_out}, {16'h0000, e[31:16]});
                    check("ifid_pc", {16'h0000, pc_out}, {16'h0000, e[15:0]});
                end
            end
        end
    end

    // One clock of stimulus, entered and left at posedge+1.
    task automatic cyc(input logic r, input logic ack, input logic stall,
                       input logic redir, input logic [15:0] rpc, input string tag);
        check({tag, "_req"}, {31'd0, imem_req_out}, {31'd0, (!rst && !m_hold)});
        check({tag, "_addr"}, {16'h0000, imem_addr_out}, {16'h0000, m_pc});
        check({tag, "_valid"}, {31'd0, valid_out}, {31'd0, m_valid});

        rst            = r;
        imem_ack_in    = ack;
        imem_data_in   = m_pc ^ DATA_XOR;
        stall_in       = stall;
        redirect_in    = redir;
        redirect_pc_in = rpc;

        if (r) begin
            m_pc = RESET_PC; m_hold = 1'b0; m_valid = 1'b0;
            sb_q.delete();
        end else if (redir) begin
            m_pc = rpc; m_hold = 1'b0; m_valid = 1'b0;
            sb_q.delete();
        end else if (m_hold) begin
            if (!stall) begin
                m_hold = 1'b0; m_valid = 1'b1; m_pc = m_pc + 16'd1;
            end
        end else if (ack) begin
            sb_q.push_back({m_pc ^ DATA_XOR, m_pc});
            if (stall) m_hold = 1'b1;
            else begin
                m_valid = 1'b1; m_pc = m_pc + 16'd1;
            end
        end else if (!stall) begin
            m_valid = 1'b0;
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset state
        check("rst_instr", {16'h0000, instruc_out}, {16'h0000, NOP_INSTR});
        check("rst_pc_out", {16'h0000, pc_out}, 32'h0000_0000);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "rst");

        // 1: zero-wait memory, pcs 0..4
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "t1");
        check("t1_first_pcs", {16'h0000, pc_out}, 32'h0000_0004);

        // 3: stall for 3 cycles coincident with the ack at pc 5
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, "t3_ack");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, "t3_hold");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, "t3_hold");
        check("t3_frozen_pc", {16'h0000, pc_out}, 32'h0000_0004);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "t3_rel");
        check("t3_pc5_out", {16'h0000, pc_out}, 32'h0000_0005);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "t3_pc6");

        // 2: two wait cycles per fetch (pc 7 and 8)
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "t2_wait");
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "t2_wait");
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "t2_ack");
        end

        // 4: redirect with ack at pc 9 and stall
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, "t4_redir");
        check("t4_addr", {16'h0000, imem_addr_out}, 32'h0000_0040);
        check("t4_bubble", {31'd0, valid_out}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "t4_f40");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "t4_f41");

        // 5: back-to-back redirects, last one (16'hFFFF) wins, then wrap
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, "t5_redir_a");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, "t5_redir_b");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "t5_wrap");
        check("t5_wrap_pc", {16'h0000, pc_out}, 32'h0000_0001);

        // 6: reset while HOLD has pending data
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, "t6_ack");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, "t6_hold");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, "t6_rst");
        check("t6_instr_nop", {16'h0000, instruc_out}, {16'h0000, NOP_INSTR});
        check("t6_addr", {16'h0000, imem_addr_out}, {16'h0000, RESET_PC});
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "t6_rst");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "t6_run");
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "drain");

        check("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
